// File: rtl/wimax_pkg.sv
// Shared WiMAX PHY constants and types.
// Imported by the interleaver ping-pong controller slice.
package wimax_pkg;

    localparam int NCBPS_QPSK = 192;
    localparam int NCPC_QPSK  = 2;

    typedef enum logic {
        IDLE,
        STREAM
    } pp_state_t;

endpackage

// File: rtl/interleaver_pingpong_ctrl_if.sv
// Bit-in / symbol-out handshake bundle of the ping-pong controller.
// master = interleaver/modulator side, slave = controller.
interface interleaver_pingpong_ctrl_if #(
    parameter int NCBPS = wimax_pkg::NCBPS_QPSK,
    parameter int NCPC  = wimax_pkg::NCPC_QPSK
);
    localparam int IDXW = $clog2(NCBPS);

    logic            valid_in;
    logic            data_in;
    logic [IDXW-1:0] index_in;
    logic            ready_in;
    logic            valid_out;
    logic [NCPC-1:0] data_out;
    logic            ready_mod;
    logic            block_done;
    logic            idx_err;

    modport master (
        output valid_in, data_in, index_in, ready_mod,
        input  ready_in, valid_out, data_out, block_done, idx_err
    );

    modport slave (
        input  valid_in, data_in, index_in, ready_mod,
        output ready_in, valid_out, data_out, block_done, idx_err
    );

endinterface

// File: rtl/pp_bit_bank.sv
// Two NCBPS-bit flop banks: one bit-write port, one NCPC-wide read port.
// Contents are deliberately not reset.
module pp_bit_bank #(
    parameter int NCBPS = 192,
    parameter int NCPC  = 2,
    parameter int IDXW  = $clog2(NCBPS),
    parameter int RDW   = $clog2(NCBPS / NCPC)
) (
    input  logic            clk,
    input  logic            we,
    input  logic            wr_sel,
    input  logic [IDXW-1:0] wr_addr,
    input  logic            wr_bit,
    input  logic            rd_sel,
    input  logic [RDW-1:0]  rd_addr,
    output logic [NCPC-1:0] rd_data
);

    logic [NCBPS-1:0] mem [2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_sel][wr_addr] <= wr_bit;
        end
    end

    assign rd_data = mem[rd_sel][int'(rd_addr) * NCPC +: NCPC];

endmodule

// File: rtl/interleaver_pingpong_ctrl.sv
// Ping-pong reorder buffer: scatters interleaved bits into one bank
// while the other bank is streamed in order to the modulator.
module interleaver_pingpong_ctrl
    import wimax_pkg::*;
#(
    parameter int NCBPS = NCBPS_QPSK,
    parameter int NCPC  = NCPC_QPSK
) (
    input  logic                        clk,
    input  logic                        resetN,
    interleaver_pingpong_ctrl_if.slave  bus
);

    localparam int IDXW = $clog2(NCBPS);
    localparam int NSYM = NCBPS / NCPC;
    localparam int RDW  = $clog2(NSYM);

    localparam logic [IDXW:0]   DEPTH   = (IDXW+1)'(NCBPS);
    localparam logic [IDXW-1:0] WR_LAST = IDXW'(NCBPS - 1);
    localparam logic [RDW-1:0]  RD_LAST = RDW'(NSYM - 1);

    pp_state_t       state;
    logic            wr_bank;
    logic            rd_bank;
    logic [1:0]      bank_full;
    logic [1:0]      full_nxt;
    logic [IDXW-1:0] wr_cnt;
    logic [RDW-1:0]  rd_cnt;
    logic            valid_q;
    logic            idx_err_q;
    logic            ready;
    logic            accept;
    logic            idx_ok;
    logic            wr_last;
    logic            rd_hs;
    logic            rd_last;
    logic [NCPC-1:0] rd_bits;

    assign ready   = ~bank_full[wr_bank];
    assign accept  = bus.valid_in & ready;
    assign idx_ok  = {1'b0, bus.index_in} < DEPTH;
    assign wr_last = accept & (wr_cnt == WR_LAST);
    assign rd_hs   = valid_q & bus.ready_mod;
    assign rd_last = rd_hs & (rd_cnt == RD_LAST);

    assign bus.ready_in   = ready;
    assign bus.valid_out  = valid_q;
    assign bus.data_out   = valid_q ? rd_bits : '0;
    assign bus.block_done = rd_last;
    assign bus.idx_err    = idx_err_q;

    // Fill and drain always target different banks, so both edits apply together.
    always_comb begin
        full_nxt = bank_full;
        if (wr_last) full_nxt[wr_bank] = 1'b1;
        if (rd_last) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            bank_full <= 2'b00;
            idx_err_q <= 1'b0;
        end else begin
            bank_full <= full_nxt;
            if (accept) begin
                if (!idx_ok) idx_err_q <= 1'b1;
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bank_full[rd_bank]) begin
                        state   <= STREAM;
                        valid_q <= 1'b1;
                    end
                end
                STREAM: begin
                    if (rd_last) begin
                        rd_cnt  <= '0;
                        rd_bank <= ~rd_bank;
                        if (!bank_full[~rd_bank]) begin
                            state   <= IDLE;
                            valid_q <= 1'b0;
                        end
                    end else if (rd_hs) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    pp_bit_bank #(
        .NCBPS (NCBPS),
        .NCPC  (NCPC),
        .IDXW  (IDXW),
        .RDW   (RDW)
    ) u_bank (
        .clk     (clk),
        .we      (accept & idx_ok),
        .wr_sel  (wr_bank),
        .wr_addr (bus.index_in),
        .wr_bit  (bus.data_in),
        .rd_sel  (rd_bank),
        .rd_addr (rd_cnt),
        .rd_data (rd_bits)
    );

endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// Scoreboard bench for the ping-pong controller: writer pushes the
// expected symbol stream, a negedge monitor pops and compares.
module tb_interleaver_pingpong_ctrl;

    localparam int NCBPS = 192;
    localparam int NCPC  = 2;
    localparam int NSYM  = NCBPS / NCPC;
    localparam int IDXW  = 8;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    interleaver_pingpong_ctrl_if #(.NCBPS(NCBPS), .NCPC(NCPC)) bus ();

    interleaver_pingpong_ctrl #(.NCBPS(NCBPS), .NCPC(NCPC)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [1:0] sb[$];
    bit model[2][NCBPS];
    bit mwb = 1'b0;
    int blk_idx[NCBPS];
    bit blk_dat[NCBPS];
    int cyc = 0;
    int acc_total = 0;
    int hs_total = 0;
    int done_total = 0;
    int done_at_hs = -1;
    int first_valid_cyc = -1;
    int last_acc_cyc = 0;
    bit rm_rand = 1'b0;
    bit held = 1'b0;
    bit writer_done = 1'b0;
    logic [1:0] held_data = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rm_rand) begin
            #1;
            bus.ready_mod = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compare every handshaken symbol and the hold-while-stalled rule.
    always @(negedge clk) begin
        if (!resetN) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (!bus.valid_out || bus.data_out !== held_data) begin
                    errors++;
                    $display("FAIL hold: valid=%0d data=%0d expected valid=1 data=%0d",
                             bus.valid_out, bus.data_out, held_data);
                end
            end
            if (bus.valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.valid_out && bus.ready_mod) begin
                hs_total++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL symbol: got %0d expected none (queue empty)", bus.data_out);
                end else begin
                    logic [1:0] exp;
                    exp = sb.pop_front();
                    if (bus.data_out !== exp) begin
                        errors++;
                        $display("FAIL symbol %0d: got %0d expected %0d",
                                 hs_total, bus.data_out, exp);
                    end
                end
            end
            if (bus.block_done) begin
                done_total++;
                done_at_hs = hs_total;
            end
            held = bus.valid_out && !bus.ready_mod;
            held_data = bus.data_out;
        end
    end

    task automatic set_linear();
        for (int k = 0; k < NCBPS; k++) begin
            blk_idx[k] = k;
            blk_dat[k] = k[0];
        end
    endtask

    task automatic set_perm(input int seed);
        for (int k = 0; k < NCBPS; k++) begin
            blk_idx[k] = 12 * (k % 16) + k / 16;
            blk_dat[k] = 1'((k * k * seed + 3 * k + seed) >> 3);
        end
    endtask

    task automatic send_block();
        for (int k = 0; k < NCBPS; k++) begin
            int w;
            w = 0;
            bus.valid_in = 1'b1;
            bus.data_in  = blk_dat[k];
            bus.index_in = IDXW'(blk_idx[k]);
            while (!bus.ready_in) begin
                @(posedge clk);
                #1;
                w++;
                if (w > 3000) begin
                    checks++;
                    errors++;
                    $display("FAIL write_stall: got ready_in=0 for %0d cycles expected 1", w);
                    bus.valid_in = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            if (blk_idx[k] < NCBPS) model[mwb][blk_idx[k]] = blk_dat[k];
            acc_total++;
            #1;
            last_acc_cyc = cyc;
        end
        bus.valid_in = 1'b0;
        for (int s = 0; s < NSYM; s++)
            sb.push_back({model[mwb][2*s+1], model[mwb][2*s]});
        mwb = ~mwb;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (sb.size() != 0 && w < 6000) begin
            @(posedge clk);
            w++;
        end
        chk({name, "_drain_left"}, sb.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetN = 1'b0;
        bus.valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        mwb = 1'b0;
        resetN = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int h0;
        int a0;
        int c1;
        int c2;
        int w;
        bus.valid_in  = 1'b0;
        bus.data_in   = 1'b0;
        bus.index_in  = '0;
        bus.ready_mod = 1'b0;
        #12;
        chk("rst_ready_in", int'(bus.ready_in), 1);
        chk("rst_valid_out", int'(bus.valid_out), 0);
        chk("rst_data_out", int'(bus.data_out), 0);
        chk("rst_block_done", int'(bus.block_done), 0);
        chk("rst_idx_err", int'(bus.idx_err), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;

        // 1: linear block, latency and 2'b10 symbols
        bus.ready_mod = 1'b1;
        first_valid_cyc = -1;
        d0 = done_total;
        h0 = hs_total;
        set_linear();
        send_block();
        drain("t1");
        chk("t1_latency", first_valid_cyc - last_acc_cyc, 1);
        chk("t1_done", done_total - d0, 1);
        chk("t1_done_at", done_at_hs - h0, NSYM);
        chk("t1_idx_err", int'(bus.idx_err), 0);

        // 2: interleaver permutation
        d0 = done_total;
        set_perm(5);
        send_block();
        drain("t2");
        chk("t2_done", done_total - d0, 1);

        // 3: three blocks against a stalled modulator
        bus.ready_mod = 1'b0;
        d0 = done_total;
        a0 = acc_total;
        writer_done = 1'b0;
        fork
            begin
                set_perm(9);
                send_block();
                set_linear();
                send_block();
                set_perm(13);
                send_block();
                writer_done = 1'b1;
            end
        join_none
        w = 0;
        while (acc_total - a0 < 2 * NCBPS && w < 2000) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t3_ready_in", int'(bus.ready_in), 0);
        chk("t3_accepted", acc_total - a0, 2 * NCBPS);
        chk("t3_valid_out", int'(bus.valid_out), 1);
        bus.ready_mod = 1'b1;
        h0 = hs_total;
        c1 = -1;
        c2 = -1;
        w = 0;
        while (c2 < 0 && w < 1000) begin
            @(posedge clk);
            #2;
            w++;
            if (c1 < 0 && hs_total >= h0 + 1) c1 = cyc;
            if (hs_total >= h0 + 2 * NSYM) c2 = cyc;
        end
        chk("t3_no_bubble", c2 - c1, 2 * NSYM - 1);
        w = 0;
        while (!writer_done && w < 3000) begin
            @(posedge clk);
            w++;
        end
        chk("t3_writer_done", int'(writer_done), 1);
        drain("t3");
        chk("t3_done", done_total - d0, 3);

        // 4: random modulator back-pressure
        d0 = done_total;
        rm_rand = 1'b1;
        set_perm(21);
        send_block();
        set_perm(2);
        send_block();
        drain("t4");
        rm_rand = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        bus.ready_mod = 1'b1;
        chk("t4_done", done_total - d0, 2);

        // 5: out-of-range index is sticky
        d0 = done_total;
        set_perm(17);
        blk_idx[5] = 200;
        send_block();
        drain("t5a");
        chk("t5_idx_err", int'(bus.idx_err), 1);
        set_linear();
        send_block();
        drain("t5b");
        chk("t5_idx_err_sticky", int'(bus.idx_err), 1);
        chk("t5_done", done_total - d0, 2);

        // 6: reset mid-stream, then a fresh block from bank 0
        do_reset();
        chk("t6_idx_err_clr", int'(bus.idx_err), 0);
        set_perm(29);
        h0 = hs_total;
        send_block();
        w = 0;
        while (hs_total < h0 + 40 && w < 1000) begin
            @(posedge clk);
            #2;
            w++;
        end
        chk("t6_sym_pos", hs_total - h0, 40);
        resetN = 1'b0;
        #1;
        chk("t6_valid_out", int'(bus.valid_out), 0);
        chk("t6_ready_in", int'(bus.ready_in), 1);
        chk("t6_left", sb.size(), NSYM - 40);
        sb.delete();
        mwb = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        d0 = done_total;
        set_perm(3);
        for (int k = 0; k < NCBPS; k++) blk_dat[k] = ~blk_dat[k];
        send_block();
        drain("t6");
        chk("t6_done", done_total - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
